// File: rtl/icache_ro_nway.sv
// icache_ro_nway: parametrised read-only N-way set-associative instruction cache
// with true-LRU replacement, RVC halfword fetches (including block straddles)
// and saturating access / miss counters.
//
// Ports
//   clk, proc_reset           clock, synchronous active-high reset
//   proc_read/addr/pcadd      fetch request: 30-bit word address, halfword select
//   proc_rdata, proc_stall    fetched instruction bits, request-not-serviced flag
//   mem_read/addr             block read request to instruction memory (28-bit block addr)
//   mem_write, mem_wdata      unused write channel, tied to 0
//   mem_rdata, mem_ready      returned 128-bit block and its one-cycle strobe
//   acc_cnt, miss_cnt         completed fetches / block fills started (saturating)
//
// Handshake: a fetch is accepted in the cycle where proc_read=1 and proc_stall=0;
// while proc_stall=1 the requester holds proc_addr/proc_pcadd stable. A fill is
// requested by holding mem_read=1 with a stable mem_addr until a single-cycle
// mem_ready=1 returns the block; mem_ready in any other state is ignored.
module icache_ro_nway #(
  parameter int WAYS = 4,
  parameter int SETS = 4
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic [29:0]  proc_addr,
  input  logic         proc_pcadd,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [31:0]  acc_cnt,
  output logic [31:0]  miss_cnt
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 28 - IW;
  localparam int AW = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, FETCH, REFILL_DONE} state_t;

  typedef logic [WAYS-1:0][AW-1:0] ages_t;

  state_t state_q;

  logic [127:0]    data_q  [WAYS][SETS];
  logic [TW-1:0]   tag_q   [WAYS][SETS];
  logic [WAYS-1:0] valid_q [SETS];
  ages_t           age_q   [SETS];

  // Touch way h: every way younger than h ages by one, h becomes the youngest.
  function automatic ages_t lru_touch(input ages_t ages, input logic [AW-1:0] h);
    ages_t r;
    r = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (ages[w] < ages[h]) r[w] = ages[w] + AW'(1);
    end
    r[h] = '0;
    return r;
  endfunction

  // Lookup. L1 is only consulted on a straddle (offset 3), so it is simply the
  // next block, wrapping naturally at the top of the 28-bit block space.
  logic [1:0]    off;
  logic [27:0]   blk0, blk1;
  logic [IW-1:0] idx0, idx1;
  logic [TW-1:0] tag0, tag1;
  logic          straddle;

  assign off      = proc_addr[1:0];
  assign blk0     = proc_addr[29:2];
  assign blk1     = blk0 + 28'd1;
  assign idx0     = blk0[IW-1:0];
  assign idx1     = blk1[IW-1:0];
  assign tag0     = blk0[27:IW];
  assign tag1     = blk1[27:IW];
  assign straddle = proc_pcadd && (off == 2'd3);

  logic          hit0, hit1, lookup_hit;
  logic [AW-1:0] way0, way1;

  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    way0 = '0;
    way1 = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit0 && valid_q[idx0][w] && (tag_q[w][idx0] == tag0)) begin
        hit0 = 1'b1;
        way0 = AW'(w);
      end
      if (!hit1 && valid_q[idx1][w] && (tag_q[w][idx1] == tag1)) begin
        hit1 = 1'b1;
        way1 = AW'(w);
      end
    end
  end

  assign lookup_hit = hit0 && (!straddle || hit1);

  // Read data: low word at offset, high halfword from the next word (or from
  // word 0 of L1 when the fetch straddles).
  logic [127:0] line0, line1;
  logic [1:0]   off_n;
  logic [31:0]  w_lo, w_hi;

  assign line0 = data_q[way0][idx0];
  assign line1 = data_q[way1][idx1];
  assign off_n = off + 2'd1;

  always_comb begin
    w_lo = line0[{off, 5'd0} +: 32];
    w_hi = straddle ? line1[31:0] : line0[{off_n, 5'd0} +: 32];
    proc_rdata = proc_pcadd ? {w_hi[15:0], w_lo[31:16]} : w_lo;
  end

  assign proc_stall = (state_q != IDLE) || (proc_read && !lookup_hit);
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;

  // The fill target is held in mem_addr for the whole FETCH state, so the set
  // and tag being filled come straight from it.
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic [AW-1:0] victim;
  logic          free_found;
  logic          fill_we;

  assign fill_idx = mem_addr[IW-1:0];
  assign fill_tag = mem_addr[27:IW];
  assign fill_we  = (state_q == FETCH) && mem_ready && !proc_reset;

  always_comb begin
    victim     = '0;
    free_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!free_found && !valid_q[fill_idx][w]) begin
        free_found = 1'b1;
        victim     = AW'(w);
      end
    end
    if (!free_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[fill_idx][w] == AW'(WAYS - 1)) victim = AW'(w);
      end
    end
  end

  // Line storage carries no reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[victim][fill_idx] <= mem_rdata;
      tag_q[victim][fill_idx]  <= fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      mem_read <= 1'b0;
      mem_addr <= '0;
      acc_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (proc_read) begin
            if (lookup_hit) begin
              age_q[idx0] <= lru_touch(age_q[idx0], way0);
              if (straddle) age_q[idx1] <= lru_touch(age_q[idx1], way1);
              if (acc_cnt != 32'hFFFF_FFFF) acc_cnt <= acc_cnt + 32'd1;
            end else begin
              state_q  <= FETCH;
              mem_read <= 1'b1;
              mem_addr <= hit0 ? blk1 : blk0;
              if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
          end
        end
        FETCH: begin
          if (mem_ready) begin
            valid_q[fill_idx][victim] <= 1'b1;
            age_q[fill_idx]           <= lru_touch(age_q[fill_idx], victim);
            mem_read                  <= 1'b0;
            state_q                   <= REFILL_DONE;
          end
        end
        REFILL_DONE: state_q <= IDLE;
        default:     state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache_ro_nway.md
Name: icache_ro_nway

Overview:
- Parametrised read-only instruction cache. Successor to the fixed 2-way I-cache.
- Sits between the RISC-V pipeline fetch port and the slow instruction memory. Adds a configurable way count, configurable set count and true-LRU replacement.
- Supports RVC halfword-aligned 32-bit fetches, including fetches that straddle two cache blocks.
- Provides access and miss counters for hit-rate analysis.

Parameters:
- WAYS, 4: associativity. Power of two, 2..8.
- SETS, 4: sets per way. Power of two, >=2.
- Block size is fixed at 4 words (128 bits), matching the memory bus.
- Index width IW = log2(SETS). Tag width TW = 28 - IW.

Ports:
- clk  in  1  clock.
- proc_reset  in  1  synchronous, active-high reset.
- proc_read  in  1  fetch request.
- proc_addr  in  30  word address of the fetch.
- proc_pcadd  in  1  RVC halfword select. 1 = fetch starts at bits [31:16] of word proc_addr.
- proc_rdata  out  32  fetched instruction bits.
- proc_stall  out  1  request not yet serviced.
- mem_read  out  1  block read request.
- mem_write  out  1  tied 0.
- mem_addr  out  28  block address (byte address [31:4]).
- mem_wdata  out  128  tied 0.
- mem_rdata  in  128  returned block.
- mem_ready  in  1  one-cycle completion strobe.
- acc_cnt  out  32  completed fetches, saturating.
- miss_cnt  out  32  block fills started, saturating.

Behaviour:
- One clock (clk); synchronous active-high reset (proc_reset).
- Reset values:
  - all valid bits 0
  - LRU age of way w = w in every set
  - FSM in IDLE
  - mem_read=0, mem_addr=0
  - acc_cnt=0, miss_cnt=0
- Address split for word address A: offset = A[1:0], index = A[IW+1:2], tag = A[29:IW+2].
- Line L0 = block holding proc_addr.
  - Straddle occurs when proc_pcadd=1 and offset==3; line L1 = block holding proc_addr+1 (30-bit wrap: 0x3FFFFFFF+1 = 0).
  - Without a straddle, L1 is not used.
- proc_rdata (combinational):
  - proc_pcadd=0: word[offset] of L0.
  - proc_pcadd=1, offset<3: {word[offset+1][15:0], word[offset][31:16]}.
  - straddle: {L1.word0[15:0], L0.word3[31:16]}.
- Hit: every required line matches a valid way in its set.
  - proc_stall=0 in the same cycle.
  - Ages update at the clock edge: for the hit way h, ages below age[h] increment and age[h] becomes 0.
  - On a straddle hit, both sets are updated.
- proc_read=0: proc_stall=0, no state change.
- FSM states:
  - IDLE: on proc_read with a miss, proc_stall=1 and go to FETCH. The target is L0 if L0 misses, else L1.
  - FETCH: mem_read=1, mem_addr={tag,index} of the target, both held stable until mem_ready=1.
    - On mem_ready: write mem_rdata into the victim way, set valid, install the tag, apply the LRU update, go to REFILL_DONE. miss_cnt increments on entry to FETCH.
    - Victim = lowest-index invalid way, else the way whose age==WAYS-1.
  - REFILL_DONE: mem_read=0, proc_stall=1, return to IDLE next cycle. The lookup repeats there; a straddle with the other line still missing triggers a second fill.
- proc_stall is 1 in FETCH and REFILL_DONE.
- Miss latency: with mem_ready at cycle k after FETCH entry, the hit is delivered at cycle k+2. The processor holds proc_addr and proc_pcadd stable while stalled.
- acc_cnt increments on every cycle with proc_read=1 and proc_stall=0. Both counters saturate at 0xFFFFFFFF.
- Reset mid-fill: return to IDLE, mem_read=0 on the next cycle, no line is written, any later mem_ready is ignored.
- mem_ready outside FETCH: ignored.

Test Plan:
- Cold fetch at addr 0x00000010, pcadd=0, memory latency 5 -> stall; mem_read with mem_addr 0x0000004; fill; rdata = mem word0 two cycles after mem_ready; acc_cnt=1, miss_cnt=1.
- Refetch 0x10..0x13 with pcadd=0 and 1 -> no stall; correct halfword-concatenated data each cycle; miss_cnt unchanged.
- WAYS+1 distinct tags in set 0, then re-access tag 0 -> 5th fill evicts tag 0, the oldest; re-access of tag 0 misses and evicts tag 1.
- Straddle, addr 0x13, pcadd=1, both lines cold -> two fills, mem_addr 0x0000004 then 0x0000005; rdata = {L1w0[15:0], L0w3[31:16]}; miss_cnt=2.
- Straddle at addr 0x3FFFFFFF -> second fill at mem_addr 0x0000000.
- proc_reset asserted while mem_read=1 -> mem_read=0 next cycle; a late mem_ready has no effect; refetch misses again.
